uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter MAX_UART_DATA_W, default 8, the width of one UART character.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, the number of FIFO entries; it must be a power of two and at least 2.
REQ-003 SHALL have parameter FIFO_ADDR_W, default 4, equal to log2(FIFO_DEPTH).
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_ni, input, 1 bit, the reset; it is synchronous and active-low.
REQ-006 SHALL have port wr_valid_i, input, 1 bit, meaning the producer offers a character.
REQ-007 SHALL have port wr_data_i, input, MAX_UART_DATA_W bits, the offered character.
REQ-008 SHALL have port wr_ready_o, output, 1 bit, meaning the FIFO can accept a character.
REQ-009 SHALL have port flush_i, input, 1 bit, which discards all queued characters.
REQ-010 SHALL have port tx_busy_i, input, 1 bit, the busy status from the UART Tx path.
REQ-011 SHALL have port tx_done_i, input, 1 bit, the one-cycle done pulse from the UART Tx path.
REQ-012 SHALL have port tx_start_o, output, 1 bit, a one-cycle pulse that launches transmission of one character.
REQ-013 SHALL have port tx_data_o, output, MAX_UART_DATA_W bits, the character being transmitted.
REQ-014 SHALL have port empty_o, output, 1 bit, asserted when the FIFO is empty.
REQ-015 SHALL have port full_o, output, 1 bit, asserted when the FIFO is full.

Function
REQ-016 SHALL accept a write exactly when wr_valid_i=1 and wr_ready_o=1, where wr_ready_o = !full_o; data offered when full is not stored, and wr_data_i is ignored when not accepted.
REQ-017 SHALL track occupancy with read/write pointers of FIFO_ADDR_W+1 bits that wrap at 2*FIFO_DEPTH: empty when the pointers are equal, full when the MSBs differ and the remaining bits are equal.
REQ-018 SHALL use sequencer FSM states IDLE and WAIT_DONE.
REQ-019 SHALL, in IDLE with empty_o=0 and tx_busy_i=0, at the next edge register the head entry onto tx_data_o, set tx_start_o=1 for exactly one cycle, advance the read pointer, and enter WAIT_DONE.
REQ-020 SHALL hold tx_data_o stable in WAIT_DONE and return to IDLE on the edge where tx_done_i=1; tx_busy_i is not examined in WAIT_DONE.
REQ-021 SHALL give a latency of 2 cycles: a write accepted in cycle N to an empty FIFO, with the block in IDLE and tx_busy_i=0, produces tx_start_o=1 in cycle N+2.
REQ-022 SHALL, after tx_done_i=1 in cycle M with the FIFO non-empty and tx_busy_i=0, assert the next tx_start_o in cycle M+2.
REQ-023 SHALL handle a simultaneous accepted write and pop by moving both pointers; occupancy is unchanged and full_o stays high if it was high.
REQ-024 SHALL NOT bypass data: a write into an empty FIFO is not launched in the same cycle.
REQ-025 SHALL, on flush_i=1, set the read pointer equal to the write pointer at the next edge; an in-flight character is not aborted and the FSM state is kept.
REQ-026 SHALL drop a write presented in the same cycle as flush_i=1, and SHALL suppress a launch in that cycle.
REQ-027 SHALL ignore tx_done_i while in IDLE.

Reset
REQ-028 SHALL, while rst_ni=0 at a clock edge, clear both pointers, set the FSM to IDLE, and drive tx_start_o=0, tx_data_o=0, empty_o=1, full_o=0 and wr_ready_o=1.
REQ-029 SHALL, on a reset during WAIT_DONE, lose all queued data and the in-flight character; the block does not wait for tx_done_i.
REQ-030 SHALL NOT reset the storage array.

Configuration
REQ-031 SHALL, when macro UART_TX_FIFO_LEVEL_EN is defined, add output port level_o of FIFO_ADDR_W+1 bits giving the stored entry count (0..FIFO_DEPTH), registered, with reset value 0.
REQ-032 SHALL, when UART_TX_FIFO_LEVEL_EN is not defined, omit level_o and its logic; all other behaviour is identical.

Structure
REQ-033 SHALL take the FSM state encodings and the default FIFO_DEPTH from the shared UART package/include, alongside the existing UART width constants.
REQ-034 SHALL place storage and pointers in a sub-module sync_fifo, which has push/pop/flush controls and full/empty/head outputs; the sequencer FSM stays in uart_tx_fifo.

Verification
REQ-035 SHALL verify single character: write 0xA5 in cycle 0 with tx_busy_i=0 -> tx_start_o=1 in cycle 2 with tx_data_o=0xA5, and empty_o=1 from cycle 2.
REQ-036 SHALL verify fill: 16 writes with tx_busy_i held 1 -> full_o=1 and wr_ready_o=0 after the 16th; a 17th write (0xFF) is not stored, and the 16 characters emerge in order.
REQ-037 SHALL verify back-to-back: queue 0x01, 0x02, 0x03 and model tx_done_i 10 cycles after each tx_start_o -> three start pulses with matching data, each 2 cycles after the preceding tx_done_i.
REQ-038 SHALL verify flush: queue 4 characters, flush_i=1 during the first WAIT_DONE -> the first character completes, no further tx_start_o occurs, and empty_o=1.
REQ-039 SHALL verify reset: rst_ni=0 for 1 cycle during WAIT_DONE with 3 characters queued -> all outputs at reset values, and no tx_start_o after a later tx_done_i.
REQ-040 SHALL verify level: with UART_TX_FIFO_LEVEL_EN defined, 5 writes followed by 2 launches -> level_o reads 5, then 3.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART constants: character width, default Tx FIFO depth and Tx sequencer state encodings.
package uart_tx_fifo_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int UART_FIFO_DEPTH  = 16;
    localparam int UART_FIFO_ADDR_W = $clog2(UART_FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_DONE = 1'b1
    } tx_seq_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, flush and a combinational head; push/pop land at the next edge.
// Push is ignored when full or flushing, pop when empty or flushing; storage is not reset.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] head_o
);

    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]   rptr_q, rptr_d;
    logic              push_ok;
    logic              pop_ok;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                     (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
    assign head_o  = mem_q[rptr_q[ADDR_W-1:0]];

    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            // Drain by catching the read side up; the write side never moves on a flush.
            rptr_d = wptr_q;
        end else begin
            if (push_ok) wptr_d = wptr_q + PTR_ONE;
            if (pop_ok)  rptr_d = rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q[ADDR_W-1:0]] <= data_i;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART Tx character queue + launch sequencer: 2-cycle write-to-start, next start 2 cycles after tx_done; wr_ready_o = !full.
// Optional registered occupancy output level_o when UART_TX_FIFO_LEVEL_EN is defined.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int MAX_UART_DATA_W = UART_DATA_W,
    parameter int FIFO_DEPTH      = UART_FIFO_DEPTH,
    parameter int FIFO_ADDR_W     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       wr_valid_i,
    input  logic [MAX_UART_DATA_W-1:0] wr_data_i,
    output logic                       wr_ready_o,
    input  logic                       flush_i,
    input  logic                       tx_busy_i,
    input  logic                       tx_done_i,
    output logic                       tx_start_o,
    output logic [MAX_UART_DATA_W-1:0] tx_data_o,
    output logic                       empty_o,
    output logic                       full_o
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    output logic [FIFO_ADDR_W:0]       level_o
`endif
);

    tx_seq_state_e              state_q, state_d;
    logic                       tx_start_q, tx_start_d;
    logic [MAX_UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic [MAX_UART_DATA_W-1:0] head;
    logic                       fifo_full, fifo_empty;
    logic                       push, pop;

    assign wr_ready_o = !fifo_full;
    assign push       = wr_valid_i && wr_ready_o;
    assign empty_o    = fifo_empty;
    assign full_o     = fifo_full;
    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;

    sync_fifo #(
        .DATA_W (MAX_UART_DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (FIFO_ADDR_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (wr_data_i),
        .pop_i   (pop),
        .flush_i (flush_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A flush in this cycle wins over launching the head entry.
                if (!fifo_empty && !tx_busy_i && !flush_i) begin
                    pop        = 1'b1;
                    tx_start_d = 1'b1;
                    tx_data_d  = head;
                    state_d    = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done_i) state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

`ifdef UART_TX_FIFO_LEVEL_EN
    localparam logic [FIFO_ADDR_W:0] LVL_ONE = (FIFO_ADDR_W+1)'(1);

    logic [FIFO_ADDR_W:0] level_q, level_d;

    always_comb begin
        level_d = level_q;
        if (flush_i) begin
            level_d = '0;
        end else if (push && !pop) begin
            level_d = level_q + LVL_ONE;
        end else if (pop && !push) begin
            level_d = level_q - LVL_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) level_q <= '0;
        else         level_q <= level_d;
    end

    assign level_o = level_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: reset, single char, fill, back-to-back, flush, reset in flight, optional level.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic       flush = 1'b0;
    logic       tx_busy = 1'b0;
    logic       tx_done = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       empty;
    logic       full;
`ifdef UART_TX_FIFO_LEVEL_EN
    logic [4:0] level;
`endif

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .MAX_UART_DATA_W (8),
        .FIFO_DEPTH      (16),
        .FIFO_ADDR_W     (4)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .wr_valid_i (wr_valid),
        .wr_data_i  (wr_data),
        .wr_ready_o (wr_ready),
        .flush_i    (flush),
        .tx_busy_i  (tx_busy),
        .tx_done_i  (tx_done),
        .tx_start_o (tx_start),
        .tx_data_o  (tx_data),
        .empty_o    (empty),
        .full_o     (full)
`ifdef UART_TX_FIFO_LEVEL_EN
        ,
        .level_o    (level)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_start(input int budget, input string tag);
        for (int i = 0; i < budget && tx_start !== 1'b1; i++) step();
        checks++;
        if (tx_start !== 1'b1) begin
            fails++;
            $display("FAIL %s: tx_start_o=%b after %0d cycles, required 1", tag, tx_start, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (tx_start !== 1'b0) begin fails++; $display("FAIL rst_start: got %b want 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin fails++; $display("FAIL rst_data: got %h want 00", tx_data); end
        checks++; if (empty !== 1'b1) begin fails++; $display("FAIL rst_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin fails++; $display("FAIL rst_full: got %b want 0", full); end
        checks++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", wr_ready); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        tx_busy = 1'b0;
        wr_valid = 1'b1;
        wr_data = 8'hA5;
        step();
        wr_valid = 1'b0;
        checks++; if (tx_start !== 1'b0) begin fails++; $display("FAIL single_nobypass: start=%b want 0", tx_start); end
        checks++; if (empty !== 1'b0) begin fails++; $display("FAIL single_empty_c1: got %b want 0", empty); end
        step();
        checks++; if (tx_start !== 1'b1) begin fails++; $display("FAIL single_start_c2: got %b want 1", tx_start); end
        checks++; if (tx_data !== 8'hA5) begin fails++; $display("FAIL single_data: got %h want a5", tx_data); end
        checks++; if (empty !== 1'b1) begin fails++; $display("FAIL single_empty_c2: got %b want 1", empty); end
        step();
        checks++; if (tx_start !== 1'b0) begin fails++; $display("FAIL single_pulse_width: got %b want 0", tx_start); end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        step();
        checks++; if (tx_start !== 1'b0) begin fails++; $display("FAIL single_no_extra: got %b want 0", tx_start); end
    endtask

    task automatic test_fill();
        int extra;
        tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data = 8'(8'h10 + i);
            step();
        end
        checks++; if (full !== 1'b1) begin fails++; $display("FAIL fill_full: got %b want 1", full); end
        checks++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL fill_ready: got %b want 0", wr_ready); end
        wr_data = 8'hFF;
        step();
        wr_valid = 1'b0;
        checks++; if (full !== 1'b1) begin fails++; $display("FAIL fill_full_after17: got %b want 1", full); end
        tx_busy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wait_start(8, "fill_start");
            checks++;
            if (tx_data !== 8'(8'h10 + i)) begin
                fails++;
                $display("FAIL fill_order[%0d]: got %h want %h", i, tx_data, 8'(8'h10 + i));
            end
            step();
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
        end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (tx_start === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin fails++; $display("FAIL fill_17th_dropped: extra starts=%0d want 0", extra); end
        checks++; if (empty !== 1'b1) begin fails++; $display("FAIL fill_empty_end: got %b want 1", empty); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        int extra;
        exp[0] = 8'h01;
        exp[1] = 8'h02;
        exp[2] = 8'h03;
        tx_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data = exp[i];
            step();
        end
        wr_valid = 1'b0;
        tx_busy = 1'b0;
        wait_start(4, "b2b_first");
        checks++; if (tx_data !== exp[0]) begin fails++; $display("FAIL b2b_data[0]: got %h want %h", tx_data, exp[0]); end
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 10; j++) step();
            checks++; if (tx_data !== exp[k]) begin fails++; $display("FAIL b2b_hold[%0d]: got %h want %h", k, tx_data, exp[k]); end
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            if (k < 2) begin
                checks++; if (tx_start !== 1'b0) begin fails++; $display("FAIL b2b_early[%0d]: start=%b want 0", k + 1, tx_start); end
                step();
                checks++; if (tx_start !== 1'b1) begin fails++; $display("FAIL b2b_lat[%0d]: start=%b want 1", k + 1, tx_start); end
                checks++; if (tx_data !== exp[k+1]) begin fails++; $display("FAIL b2b_data[%0d]: got %h want %h", k + 1, tx_data, exp[k+1]); end
            end
        end
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (tx_start === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin fails++; $display("FAIL b2b_no_extra: extra starts=%0d want 0", extra); end
    endtask

    task automatic test_flush();
        int extra;
        tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data = 8'(8'h40 + i);
            step();
        end
        wr_valid = 1'b0;
        tx_busy = 1'b0;
        wait_start(4, "flush_first");
        checks++; if (tx_data !== 8'h40) begin fails++; $display("FAIL flush_first_data: got %h want 40", tx_data); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (empty !== 1'b1) begin fails++; $display("FAIL flush_empty: got %b want 1", empty); end
        for (int i = 0; i < 4; i++) step();
        checks++; if (tx_data !== 8'h40) begin fails++; $display("FAIL flush_inflight_hold: got %h want 40", tx_data); end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (tx_start === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin fails++; $display("FAIL flush_no_start: extra starts=%0d want 0", extra); end
        // A write coinciding with a flush must be dropped.
        tx_busy = 1'b1;
        wr_valid = 1'b1;
        wr_data = 8'h77;
        flush = 1'b1;
        step();
        wr_valid = 1'b0;
        flush = 1'b0;
        checks++; if (empty !== 1'b1) begin fails++; $display("FAIL flush_write_drop: empty=%b want 1", empty); end
        tx_busy = 1'b0;
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (tx_start === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin fails++; $display("FAIL flush_write_drop_start: extra starts=%0d want 0", extra); end
    endtask

    task automatic test_reset_in_flight();
        int extra;
        tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data = 8'(8'h50 + i);
            step();
        end
        wr_valid = 1'b0;
        tx_busy = 1'b0;
        wait_start(4, "rstwd_first");
        checks++; if (tx_data !== 8'h50) begin fails++; $display("FAIL rstwd_first_data: got %h want 50", tx_data); end
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (tx_start !== 1'b0) begin fails++; $display("FAIL rstwd_start: got %b want 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin fails++; $display("FAIL rstwd_data: got %h want 00", tx_data); end
        checks++; if (empty !== 1'b1) begin fails++; $display("FAIL rstwd_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin fails++; $display("FAIL rstwd_full: got %b want 0", full); end
        checks++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL rstwd_ready: got %b want 1", wr_ready); end
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (tx_start === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin fails++; $display("FAIL rstwd_no_start: extra starts=%0d want 0", extra); end
        // The sequencer is back in IDLE, so a fresh write launches without any tx_done.
        wr_valid = 1'b1;
        wr_data = 8'h66;
        step();
        wr_valid = 1'b0;
        step();
        checks++; if (tx_start !== 1'b1) begin fails++; $display("FAIL rstwd_relaunch: start=%b want 1", tx_start); end
        checks++; if (tx_data !== 8'h66) begin fails++; $display("FAIL rstwd_relaunch_data: got %h want 66", tx_data); end
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        step();
    endtask

`ifdef UART_TX_FIFO_LEVEL_EN
    task automatic test_level();
        tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data = 8'(8'h60 + i);
            step();
        end
        wr_valid = 1'b0;
        checks++; if (level !== 5'd5) begin fails++; $display("FAIL level_5: got %0d want 5", level); end
        tx_busy = 1'b0;
        wait_start(4, "level_launch1");
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        wait_start(4, "level_launch2");
        checks++; if (level !== 5'd3) begin fails++; $display("FAIL level_3: got %0d want 3", level); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (level !== 5'd0) begin fails++; $display("FAIL level_flush: got %0d want 0", level); end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_flush();
        test_reset_in_flight();
`ifdef UART_TX_FIFO_LEVEL_EN
        test_level();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
